// File: rtl/arm_mem_pkg.sv
// Shared types for the data-memory responder.
// Holds the FSM states and the byte-lane decode.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_RESP
  } mem_state_e;

  function automatic logic [3:0] lane_we(
    input logic [1:0] lane
  );
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core Memory stage
// and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid,
    output req_we,
    output req_byte,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  stall
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_byte,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output stall
  );

endinterface

// File: rtl/dmem_bytelane_ram.sv
// Word array with per-lane write enables and a
// registered read port; contents are not reset.
module dmem_bytelane_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: handshake,
// wait states, error check and byte lanes.
module dmem_responder
  import arm_mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam bit HAS_WAIT = (LATENCY != 0);
  localparam logic [3:0] WAIT_INIT =
    HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  mem_state_e  state_q;
  logic [3:0]  wait_q;
  logic        we_q;
  logic        byte_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rvalid_q;
  logic        rerr_q;
  logic        rload_q;

  logic        ready;
  logic        hs;
  logic        enter_resp;
  logic        live;
  logic        acc_we;
  logic        acc_byte;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;
  logic [7:0]  rd_byte;

  assign ready = (state_q != MEM_BUSY);
  assign hs    = bus.req_valid & ready;

  // Zero-latency accesses hit the array straight
  // from the port; otherwise from the latch.
  assign live      = (state_q != MEM_BUSY);
  assign acc_we    = live ? bus.req_we    : we_q;
  assign acc_byte  = live ? bus.req_byte  : byte_q;
  assign acc_addr  = live ? bus.req_addr  : addr_q;
  assign acc_wdata = live ? bus.req_wdata : wdata_q;

  assign enter_resp = ~reset & (
    ((state_q == MEM_BUSY) & (wait_q == 4'd0)) |
    (hs & ~HAS_WAIT));

  assign acc_err =
    (~acc_byte & (acc_addr[1:0] != 2'b00)) |
    (acc_addr[31:2] >= 30'(DEPTH));

  assign ram_we =
    {4{enter_resp & acc_we & ~acc_err}} &
    (acc_byte ? lane_we(acc_addr[1:0]) : 4'hF);

  assign ram_wdata =
    acc_byte ? {4{acc_wdata[7:0]}} : acc_wdata;

  dmem_bytelane_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (enter_resp),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MEM_IDLE;
      wait_q   <= 4'd0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rload_q  <= 1'b0;
    end else begin
      rvalid_q <= enter_resp;
      rerr_q   <= enter_resp & acc_err;
      rload_q  <= enter_resp & ~acc_we & ~acc_err;
      if (hs) begin
        we_q    <= bus.req_we;
        byte_q  <= bus.req_byte;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      unique case (state_q)
        MEM_IDLE, MEM_RESP: begin
          if (hs) begin
            state_q <= HAS_WAIT ? MEM_BUSY : MEM_RESP;
            wait_q  <= WAIT_INIT;
          end else begin
            state_q <= MEM_IDLE;
          end
        end
        MEM_BUSY: begin
          if (wait_q == 4'd0) begin
            state_q <= MEM_RESP;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  assign rd_byte = ram_q[{addr_q[1:0], 3'b000} +: 8];

  assign bus.req_ready  = ready;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_err   = rerr_q;
  assign bus.resp_rdata =
    !rload_q ? 32'h0 :
    byte_q   ? {24'h0, rd_byte} : ram_q;
  assign bus.stall =
    (state_q == MEM_BUSY) |
    (hs & HAS_WAIT) |
    (bus.req_valid & ~ready);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2
// and LATENCY 0, with hand-computed expectations.
module tb_dmem_responder;

  logic clk;
  logic reset;
  int   npass;
  int   ntot;

  dmem_responder_if b2 ();
  dmem_responder_if b0 ();

  dmem_responder #(
    .DEPTH   (64),
    .LATENCY (2)
  ) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  dmem_responder #(
    .DEPTH   (64),
    .LATENCY (0)
  ) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic acc2(
    input  logic        we,
    input  logic        byt,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output int          stl
  );
    int n;
    rd  = '0;
    er  = 1'b0;
    lat = -1;
    stl = 0;
    n   = 0;
    b2.req_valid = 1'b1;
    b2.req_we    = we;
    b2.req_byte  = byt;
    b2.req_addr  = addr;
    b2.req_wdata = wd;
    do begin
      @(negedge clk);
      if (b2.stall) stl++;
      n++;
    end while (!b2.req_ready && n < 20);
    @(posedge clk);
    #1 b2.req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b2.stall) stl++;
      if (b2.resp_valid) begin
        lat = i;
        rd  = b2.resp_rdata;
        er  = b2.resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(
    input string       tag,
    input logic        we,
    input logic        byt,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] exp_rd,
    input logic        exp_er
  );
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          stl;
    acc2(we, byt, addr, wd, rd, er, lat, stl);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_stall"}, 32'(stl), 32'd3);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
    chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  logic [31:0] wv [4];
  int          cnt;

  initial begin
    npass = 0;
    ntot  = 0;
    wv[0] = 32'h01020304;
    wv[1] = 32'hA0B0C0D0;
    wv[2] = 32'h0000FFFF;
    wv[3] = 32'h80000001;
    reset = 1'b1;
    b2.req_valid = 1'b0;
    b2.req_we    = 1'b0;
    b2.req_byte  = 1'b0;
    b2.req_addr  = '0;
    b2.req_wdata = '0;
    b0.req_valid = 1'b0;
    b0.req_we    = 1'b0;
    b0.req_byte  = 1'b0;
    b0.req_addr  = '0;
    b0.req_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, b2.resp_valid}, 32'd0);
    chk("rst_rdata", b2.resp_rdata, 32'd0);
    chk("rst_err", {31'd0, b2.resp_err}, 32'd0);
    chk("rst_ready", {31'd0, b2.req_ready}, 32'd1);
    chk("rst_stall", {31'd0, b2.stall}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    xfer("st_w10", 1, 0, 32'h10, 32'hDEADBEEF,
         32'h0, 1'b0);
    xfer("ld_w10", 0, 0, 32'h10, 32'h0,
         32'hDEADBEEF, 1'b0);

    xfer("st_w10b", 1, 0, 32'h10, 32'h11223344,
         32'h0, 1'b0);
    xfer("st_b12", 1, 1, 32'h12, 32'hFFFFFFA5,
         32'h0, 1'b0);
    xfer("ld_w10b", 0, 0, 32'h10, 32'h0,
         32'h11A53344, 1'b0);
    xfer("ld_b13", 0, 1, 32'h13, 32'h0,
         32'h00000011, 1'b0);

    xfer("st_w00", 1, 0, 32'h00, 32'hCAFEF00D,
         32'h0, 1'b0);
    xfer("ld_mis06", 0, 0, 32'h06, 32'h0,
         32'h0, 1'b1);
    xfer("st_oor100", 1, 0, 32'h100, 32'h12345678,
         32'h0, 1'b1);
    xfer("ld_w00", 0, 0, 32'h00, 32'h0,
         32'hCAFEF00D, 1'b0);

    // LATENCY 0: streamed stores then loads
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        b0.req_valid = 1'b1;
        b0.req_we    = 1'b1;
        b0.req_addr  = 32'(i * 4);
        b0.req_wdata = wv[i];
      end else begin
        b0.req_valid = 1'b0;
      end
      @(negedge clk);
      chk("l0_st_stall", {31'd0, b0.stall}, 32'd0);
      if (i > 0) begin
        chk("l0_st_valid", {31'd0, b0.resp_valid},
            32'd1);
        chk("l0_st_err", {31'd0, b0.resp_err}, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        b0.req_valid = 1'b1;
        b0.req_we    = 1'b0;
        b0.req_addr  = 32'(i * 4);
      end else begin
        b0.req_valid = 1'b0;
      end
      @(negedge clk);
      chk("l0_ld_stall", {31'd0, b0.stall}, 32'd0);
      chk("l0_ld_ready", {31'd0, b0.req_ready}, 32'd1);
      if (i > 0) begin
        chk("l0_ld_valid", {31'd0, b0.resp_valid},
            32'd1);
        chk("l0_ld_rdata", b0.resp_rdata, wv[i-1]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("l0_idle_valid", {31'd0, b0.resp_valid}, 32'd0);
    @(posedge clk);
    #1;

    // reset while a store is waiting
    xfer("st_w20", 1, 0, 32'h20, 32'h0BADF00D,
         32'h0, 1'b0);
    b2.req_valid = 1'b1;
    b2.req_we    = 1'b1;
    b2.req_byte  = 1'b0;
    b2.req_addr  = 32'h20;
    b2.req_wdata = 32'h55555555;
    @(negedge clk);
    @(posedge clk);
    #1 b2.req_valid = 1'b0;
    @(negedge clk);
    chk("busy_stall", {31'd0, b2.stall}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_valid", {31'd0, b2.resp_valid}, 32'd0);
    chk("mid_rdata", b2.resp_rdata, 32'd0);
    chk("mid_err", {31'd0, b2.resp_err}, 32'd0);
    chk("mid_ready", {31'd0, b2.req_ready}, 32'd1);
    chk("mid_stall", {31'd0, b2.stall}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (b2.resp_valid) cnt++;
    end
    chk("mid_no_resp", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    xfer("ld_w20", 0, 0, 32'h20, 32'h0,
         32'h0BADF00D, 1'b0);

    // request held while busy
    b2.req_valid = 1'b1;
    b2.req_we    = 1'b0;
    b2.req_byte  = 1'b0;
    b2.req_addr  = 32'h10;
    @(negedge clk);
    chk("bb_hs_ready", {31'd0, b2.req_ready}, 32'd1);
    @(posedge clk);
    #1 b2.req_addr = 32'h00;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk("bb_busy_ready", {31'd0, b2.req_ready},
          32'd0);
      chk("bb_busy_stall", {31'd0, b2.stall}, 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bb_r1_valid", {31'd0, b2.resp_valid}, 32'd1);
    chk("bb_r1_rdata", b2.resp_rdata, 32'h11A53344);
    chk("bb_r1_ready", {31'd0, b2.req_ready}, 32'd1);
    chk("bb_r1_stall", {31'd0, b2.stall}, 32'd1);
    @(posedge clk);
    #1 b2.req_valid = 1'b0;
    for (int i = 4; i <= 5; i++) begin
      @(negedge clk);
      chk("bb_gap_valid", {31'd0, b2.resp_valid},
          32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bb_r2_valid", {31'd0, b2.resp_valid}, 32'd1);
    chk("bb_r2_rdata", b2.resp_rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
